// File: rtl/push_down_stack.sv
// LIFO stack of DEPTH words of WIDTH bits with one push or pop per clock.
// Popped words appear on a registered output; the flags are decoded from the occupancy count.
module push_down_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             PushPop,
    input  logic             En,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_m1;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_push = En && !PushPop && !full;
    assign do_pop  = En &&  PushPop && !empty;
    assign cnt_m1  = cnt_q - CW'(1);
    assign data_o  = data_q;

    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (do_push) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop) begin
            cnt_d  = cnt_m1;
            data_d = mem[cnt_m1[AW-1:0]];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    // Storage is left uncleared; entries above cnt are unreachable after reset.
    always_ff @(posedge Clk) begin
        if (!Rst && do_push)
            mem[cnt_q[AW-1:0]] <= data_i;
    end

endmodule

// File: tb/tb_push_down_stack.sv
module tb_push_down_stack;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       PushPop = 1'b0;
    logic       En = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic [7:0] data_o;
    logic       empty, full;

    typedef struct {
        logic [7:0] d;
        logic       e;
        logic       f;
        string      name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   stim_done = 1'b0;

    push_down_stack #(.WIDTH(8), .DEPTH(256)) dut (
        .Clk(Clk), .Rst(Rst), .PushPop(PushPop), .En(En),
        .data_i(data_i), .data_o(data_o), .empty(empty), .full(full)
    );

    always #5 Clk = ~Clk;

    task automatic cyc(input logic rst, input logic en, input logic pp, input logic [7:0] din,
                       input logic [7:0] xd, input logic xe, input logic xf, input string nm);
        exp_t x;
        Rst = rst; En = en; PushPop = pp; data_i = din;
        @(posedge Clk);
        #1;
        x.d = xd; x.e = xe; x.f = xf; x.name = nm;
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge Clk);
            while (q.size() > 0) begin
                x = q.pop_front();
                total++;
                if (data_o !== x.d || empty !== x.e || full !== x.f) begin
                    bad++;
                    $display("FAIL %s: got data_o=%h empty=%b full=%b, want data_o=%h empty=%b full=%b",
                             x.name, data_o, empty, full, x.d, x.e, x.f);
                end
            end
            if (stim_done) begin
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin : stim
        cyc(1, 1, 0, 8'hEE, 8'h00, 1, 0, "reset1");
        cyc(1, 0, 0, 8'h00, 8'h00, 1, 0, "reset2");
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 0, "idle_after_reset");
        cyc(0, 1, 1, 8'h00, 8'h00, 1, 0, "pop_empty_after_reset");

        cyc(0, 1, 0, 8'd1, 8'h00, 0, 0, "push1");
        cyc(0, 0, 1, 8'hFF, 8'h00, 0, 0, "idle_a");
        cyc(0, 1, 0, 8'd2, 8'h00, 0, 0, "push2");
        cyc(0, 0, 0, 8'hFF, 8'h00, 0, 0, "idle_b");
        cyc(0, 1, 0, 8'd3, 8'h00, 0, 0, "push3");

        cyc(0, 1, 1, 8'h00, 8'd3, 0, 0, "pop3");
        cyc(0, 1, 1, 8'h00, 8'd2, 0, 0, "pop2");
        cyc(0, 1, 1, 8'h00, 8'd1, 1, 0, "pop1");
        cyc(0, 1, 1, 8'h00, 8'd1, 1, 0, "pop_ignored");

        for (int i = 1; i <= 256; i++) begin
            logic [8:0] v;
            v = 9'(i);
            cyc(0, 1, 0, v[7:0], 8'd1, 0, (i == 256), "fill_push");
        end
        cyc(0, 1, 0, 8'hAA, 8'd1, 0, 1, "push_when_full");
        cyc(0, 0, 0, 8'h55, 8'd1, 0, 1, "idle_full");
        cyc(0, 1, 1, 8'h00, 8'h00, 0, 0, "pop_top_256");
        cyc(0, 1, 1, 8'h00, 8'hFF, 0, 0, "pop_255");
        for (int i = 254; i >= 1; i--) begin
            logic [8:0] v;
            v = 9'(i);
            cyc(0, 1, 1, 8'h00, v[7:0], (i == 1), 0, "drain_pop");
        end

        cyc(0, 1, 0, 8'h5A, 8'd1,  0, 0, "il_push5a");
        cyc(0, 1, 1, 8'h00, 8'h5A, 1, 0, "il_pop5a");
        cyc(0, 1, 0, 8'h3C, 8'h5A, 0, 0, "il_push3c");
        cyc(0, 1, 0, 8'h77, 8'h5A, 0, 0, "il_push77");
        cyc(0, 1, 1, 8'h00, 8'h77, 0, 0, "il_pop77");
        cyc(0, 1, 1, 8'h00, 8'h3C, 1, 0, "il_pop3c");

        cyc(0, 1, 0, 8'd9, 8'h3C, 0, 0, "mid_push9");
        cyc(0, 1, 0, 8'd8, 8'h3C, 0, 0, "mid_push8");
        cyc(1, 1, 1, 8'h00, 8'h00, 1, 0, "mid_reset");
        cyc(0, 1, 1, 8'h00, 8'h00, 1, 0, "pop_after_reset");
        cyc(0, 1, 0, 8'h42, 8'h00, 0, 0, "push_after_reset");
        cyc(0, 1, 1, 8'h00, 8'h42, 1, 0, "pop_after_reset2");

        total++;
        if (data_o !== 8'h42) begin
            bad++;
            $display("FAIL final_data: got data_o=%h, want data_o=42", data_o);
        end
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $display("FAIL final_empty: got empty=%b, want empty=1", empty);
        end
        total++;
        if (full !== 1'b0) begin
            bad++;
            $display("FAIL final_full: got full=%b, want full=0", full);
        end

        En = 1'b0;
        stim_done = 1'b1;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/push_down_stack.md
Name: push_down_stack

Overview:
- Synchronous LIFO (push-down stack) storing WIDTH-bit words, DEPTH entries deep.
- A single enable plus a direction select (push/pop) performs at most one operation per clock.
- Popped data is presented on a registered output, and status flags report the empty and full states.
- General-purpose storage primitive for datapaths that need last-in-first-out buffering (expression evaluation, return-address stacks).

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 256, number of storage entries; power of two, ≥2.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  synchronous active-high reset.
- PushPop  input  1  operation select: 0 = push, 1 = pop; sampled only when En=1.
- En  input  1  operation enable; one operation per rising edge while high.
- data_i  input  WIDTH  word to push.
- data_o  output  WIDTH  last popped word (registered).
- empty  output  1  high when stack holds 0 entries.
- full  output  1  high when stack holds DEPTH entries.

Behaviour:
- Interface: one clock (Clk); reset Rst is synchronous and active-high. Rst=1 at a rising edge clears state regardless of En/PushPop; reset has priority over any operation.
- Internal state: storage array mem[0..DEPTH-1]; occupancy count cnt, clog2(DEPTH)+1 bits, range 0..DEPTH.
- Reset values:
  - cnt=0.
  - data_o=0.
  - empty=1.
  - full=0.
  - mem contents don't-care (need not be cleared).
- Push (En=1, PushPop=0, full=0) at a rising edge:
  - mem[cnt] <= data_i.
  - cnt <= cnt+1.
  - data_o unchanged.
- Pop (En=1, PushPop=1, empty=0) at a rising edge:
  - data_o <= mem[cnt-1].
  - cnt <= cnt-1.
  - Latency: the popped value is visible on data_o after that edge (1 cycle).
- Idle (En=0): no state change; data_o holds its last value.
- Push while full: ignored; mem, cnt and data_o unchanged; no wrap-around, no overwrite of the top.
- Pop while empty: ignored; cnt stays 0 and data_o holds its previous value.
- Continuous operation: En held high for N edges performs N operations, each subject to the full/empty guards.
  - Example: holding pop on a 3-entry stack yields 3, 2, 1 on consecutive cycles, then data_o stays at 1 with empty=1.
- Flags:
  - Registered, or combinationally derived from registered cnt; either way they update in the same cycle as cnt.
  - empty = (cnt==0).
  - full = (cnt==DEPTH).
  - Never both high.
- Push followed immediately by pop on the next edge returns the just-pushed word (no bypass needed; write completes at the earlier edge).
- Reset asserted mid-sequence: the next edge empties the stack; prior contents are unreachable afterwards.
- data_i and PushPop are don't-care when En=0.
- No combinational path from inputs to data_o.

Test Plan:
- Reset: hold Rst=1 for 2 edges, then release -> data_o=0, empty=1, full=0.
- Push 1, 2, 3 (En pulsed one cycle each, PushPop=0) -> empty=0 after the first push; full=0; data_o stays 0.
- Pop with En held high for 4 cycles after pushing 1, 2, 3 -> data_o = 3, 2, 1 on successive edges.
  - Fourth pop is ignored: data_o stays 1, empty=1 after the third pop.
- Fill: push values 1..256 -> full=1 exactly after the 256th push.
  - Extra push of 0xAA is ignored; the next pop returns 0x00 (value 256 truncated to 8 bits), the following pop returns 255.
  - full=0 after the first pop.
- Interleave: push 0x5A, pop, push 0x3C, push 0x77, pop, pop -> data_o sequence 0x5A, 0x77, 0x3C; empty=1 at the end.
- Reset mid-operation: push 9, 8; assert Rst one edge -> empty=1, data_o=0; subsequent pop is ignored (data_o stays 0).
